mips_muldiv: RTL and testbench
==============================

# mips_muldiv

Iterative multiply/divide unit for the MIPS core, sitting beside the ALU in the execute stage and owning the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU from the decoder with a start pulse and computes one radix-2 step per cycle. It holds the 64-bit result in HI/LO for MFHI/MFLO writeback, and presents a busy flag the core uses to stall issue.

## Interface
- `ITER`, default 32: iteration count; must equal the operand width. Fixed at 32 in this design.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch the operation selected by `op`; honoured only when `busy`=0.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_data`  in  32  multiplicand / dividend.
- `rt_data`  in  32  multiplier / divisor.
- `hi_we`  in  1  MTHI: load `hi` from `rs_data`.
- `lo_we`  in  1  MTLO: load `lo` from `rs_data`.
- `busy`  out  1  an operation is in progress.
- `done`  out  1  one-cycle pulse when HI/LO hold a new result.
- `div_by_zero`  out  1  sticky until next `start`; set when DIV/DIVU has divisor 0.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, RUN, FIN.
- IDLE:
  - `start`=1 latches the operands and `op`, clears `div_by_zero`, loads count=ITER, and moves to RUN.
  - Signed ops take operand magnitudes and record the result signs.
- RUN:
  - Multiply: shift-add one multiplier bit per cycle into a 64-bit accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
  - Count decrements each cycle; moves to FIN after the 32nd step.
- FIN:
  - Apply sign correction, write `hi`/`lo`, pulse `done`, return to IDLE.
- Results:
  - MULT/MULTU: {hi,lo} = 64-bit product.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero: still runs the full latency, then hi=rs_data, lo=0xFFFFFFFF, `div_by_zero`=1.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- `start` while `busy`=1 is ignored; no queueing.
- `hi_we`/`lo_we` apply only in IDLE with `start`=0.
  - If `start` and a write coincide, `start` wins and the write is dropped.
  - Writes in RUN or FIN are dropped.
- `op`, `rs_data` and `rt_data` are not sampled after the start cycle.

## Timing
- Reset (async assert, sync deassert by clock): state=IDLE; `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0; count=0.
- Start sampled at edge k:
  - `busy`=1 after edge k.
  - RUN steps on edges k+1 … k+32.
  - FIN occupies the cycle after edge k+32.
  - `hi`/`lo` update, `done`=1 and `busy`=0 after edge k+33, for one cycle.
- Latency: 33 cycles from start edge to result visible; identical for every op, including divide by zero.
- Back-to-back: a new `start` is accepted in the cycle `done` is high.
- `busy` is a registered output; the core stalls any MFHI/MFLO/mult/div issue while it is 1.
- MTHI/MTLO: new value visible one cycle after the write edge.
- Reset mid-operation aborts immediately; the partial result is discarded and all outputs return to reset values.

## Configuration
- `MULDIV_SIGNED_EN` defined:
  - MULT and DIV perform two's-complement signed arithmetic as above.
  - The overflow case applies.
- Not defined:
  - `op[0]` is ignored; MULT behaves exactly as MULTU and DIV as DIVU.
  - Sign-correction logic is not built.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, one-cycle `done` pulse.
- MULT 0xFFFFFFFB (−5) × 7 with `MULDIV_SIGNED_EN` -> hi=0xFFFFFFFF, lo=0xFFFFFFDD. Without the macro -> hi=0x00000006, lo=0xFFFFFFDD.
- DIV −7 / 2 (signed build) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=14, hi=2.
- DIVU 0x1234 / 0 -> after 33 cycles lo=0xFFFFFFFF, hi=0x00001234, `div_by_zero`=1; cleared by the next `start`.
- `start` pulsed again mid-RUN with different operands -> ignored, first result delivered unchanged. `lo_we` with rs=0xA5A5A5A5 while busy -> lo unaffected. `lo_we` in IDLE -> lo=0xA5A5A5A5 next cycle.
- `reset` driven low at cycle 10 of a MULT -> `busy`, `done`, `hi`, `lo` all 0 immediately. A fresh MULTU 3×4 after release -> lo=12, hi=0.

Source files
------------

// File: rtl/mips_muldiv.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO pair; one step per cycle, 33-cycle latency.
// Optional two's-complement MULT/DIV support is built when MULDIV_SIGNED_EN is defined.
module mips_muldiv #(
  parameter int unsigned ITER = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        hi_we,
  input  logic        lo_we,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t      state, state_nxt;
  logic [5:0]  count;
  logic [63:0] acc;
  logic [31:0] operand_b;
  logic [31:0] rs_raw;
  logic        is_div;
  logic        zero_div;
  logic [31:0] rs_mag, rt_mag;
  logic [32:0] sum, trial;
  logic [63:0] mul_next, div_next;
  logic [31:0] res_hi, res_lo;

`ifdef MULDIV_SIGNED_EN
  logic neg_q, neg_r;
  logic op_signed;

  always_comb begin
    op_signed = ~op[0];
    rs_mag = (op_signed && rs_data[31]) ? -rs_data : rs_data;
    rt_mag = (op_signed && rt_data[31]) ? -rt_data : rt_data;
  end
`else
  always_comb begin
    rs_mag = rs_data;
    rt_mag = rt_data;
  end
`endif

  // Multiply consumes the multiplier from acc[0] while the product grows in from the top;
  // divide shifts the dividend out of the low half as quotient bits shift in behind it.
  always_comb begin
    sum      = {1'b0, acc[63:32]} + {1'b0, operand_b};
    mul_next = acc[0] ? {sum, acc[31:1]} : {1'b0, acc[63:1]};
    trial    = acc[63:31] - {1'b0, operand_b};
    div_next = trial[32] ? {acc[62:0], 1'b0} : {trial[31:0], acc[30:0], 1'b1};
  end

  always_comb begin
    res_hi = acc[63:32];
    res_lo = acc[31:0];
`ifdef MULDIV_SIGNED_EN
    if (!is_div && neg_q) begin
      {res_hi, res_lo} = -acc;
    end
    if (is_div) begin
      if (neg_q) res_lo = -acc[31:0];
      if (neg_r) res_hi = -acc[63:32];
    end
`endif
    if (zero_div) begin
      res_hi = rs_raw;
      res_lo = '1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (count == 6'd1) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      acc         <= '0;
      operand_b   <= '0;
      rs_raw      <= '0;
      is_div      <= 1'b0;
      zero_div    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div      <= op[1];
            rs_raw      <= rs_data;
            zero_div    <= op[1] && (rt_data == '0);
            operand_b   <= op[1] ? rt_mag : rs_mag;
            acc         <= {32'b0, (op[1] ? rs_mag : rt_mag)};
            count       <= 6'(ITER);
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_q       <= op_signed & (rs_data[31] ^ rt_data[31]);
            neg_r       <= op_signed & op[1] & rs_data[31];
`endif
          end else begin
            if (hi_we) hi <= rs_data;
            if (lo_we) lo <= rs_data;
          end
        end
        RUN: begin
          acc   <= is_div ? div_next : mul_next;
          count <= count - 6'd1;
        end
        FIN: begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
          busy <= 1'b0;
          if (zero_div) div_by_zero <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed self-checking bench for mips_muldiv; expectations follow MULDIV_SIGNED_EN when defined.
module tb_mips_muldiv;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  mips_muldiv #(.ITER(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .hi_we(hi_we), .lo_we(lo_we),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  // Raises start for one edge, then counts edges until done (bounded at 40).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    #2;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    n_cmp++; if ({hi, lo} !== 64'h0) begin n_err++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); end
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_multu;
    int lat;
    op = MULTU; rs_data = 32'hFFFFFFFF; rt_data = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL multu_busy: got %b expected 1", busy); end
    lat = 0;
    while (!done && lat < 40) begin @(posedge clock); #1; lat++; end
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL multu_latency: got %0d expected 33", lat); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL multu_busy_end: got %b expected 0", busy); end
    n_cmp++; if (hi !== 32'hFFFFFFFE) begin n_err++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
    n_cmp++; if (lo !== 32'h00000001) begin n_err++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
    @(posedge clock); #1;
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL multu_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_mult;
    int lat;
    run_op(MULT, 32'hFFFFFFFB, 32'd7, lat);
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mult_latency: got %0d expected 33", lat); end
`ifdef MULDIV_SIGNED_EN
    n_cmp++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFDD) begin n_err++; $display("FAIL mult_neg: got %h expected ffffffffffffffdd", {hi, lo}); end
`else
    n_cmp++; if ({hi, lo} !== 64'h00000006_FFFFFFDD) begin n_err++; $display("FAIL mult_neg: got %h expected 00000006ffffffdd", {hi, lo}); end
`endif
  endtask

  task automatic test_div;
    int lat;
    run_op(DIV, 32'hFFFFFFF9, 32'd2, lat);
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL div_latency: got %0d expected 33", lat); end
`ifdef MULDIV_SIGNED_EN
    n_cmp++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin n_err++; $display("FAIL div_neg: got %h expected fffffffffffffffd", {hi, lo}); end
`else
    n_cmp++; if ({hi, lo} !== 64'h00000001_7FFFFFFC) begin n_err++; $display("FAIL div_neg: got %h expected 000000017ffffffc", {hi, lo}); end
`endif
    run_op(DIV, 32'h80000000, 32'hFFFFFFFF, lat);
`ifdef MULDIV_SIGNED_EN
    n_cmp++; if ({hi, lo} !== 64'h00000000_80000000) begin n_err++; $display("FAIL div_overflow: got %h expected 0000000080000000", {hi, lo}); end
`else
    n_cmp++; if ({hi, lo} !== 64'h80000000_00000000) begin n_err++; $display("FAIL div_overflow: got %h expected 8000000000000000", {hi, lo}); end
`endif
    run_op(DIVU, 32'd100, 32'd7, lat);
    n_cmp++; if (lo !== 32'd14) begin n_err++; $display("FAIL divu_q: got %0d expected 14", lo); end
    n_cmp++; if (hi !== 32'd2) begin n_err++; $display("FAIL divu_r: got %0d expected 2", hi); end
  endtask

  task automatic test_div_zero;
    int lat;
    run_op(DIVU, 32'h00001234, 32'd0, lat);
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL dbz_latency: got %0d expected 33", lat); end
    n_cmp++; if (lo !== 32'hFFFFFFFF) begin n_err++; $display("FAIL dbz_lo: got %h expected ffffffff", lo); end
    n_cmp++; if (hi !== 32'h00001234) begin n_err++; $display("FAIL dbz_hi: got %h expected 00001234", hi); end
    n_cmp++; if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL dbz_flag: got %b expected 1", div_by_zero); end
    repeat (3) begin @(posedge clock); #1; end
    n_cmp++; if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL dbz_sticky: got %b expected 1", div_by_zero); end
    op = MULTU; rs_data = 32'd2; rt_data = 32'd3; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL dbz_clear: got %b expected 0", div_by_zero); end
    lat = 0;
    while (!done && lat < 40) begin @(posedge clock); #1; lat++; end
    n_cmp++; if (lo !== 32'd6) begin n_err++; $display("FAIL dbz_after_lo: got %0d expected 6", lo); end
  endtask

  task automatic test_start_ignored;
    int lat;
    op = MULTU; rs_data = 32'd3; rt_data = 32'd4; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clock); #1; end
    op = DIVU; rs_data = 32'hA5A5A5A5; rt_data = 32'd7; start = 1'b1; lo_we = 1'b1; hi_we = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
    lat = 6;
    while (!done && lat < 40) begin @(posedge clock); #1; lat++; end
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL ignore_latency: got %0d expected 33", lat); end
    n_cmp++; if (lo !== 32'd12) begin n_err++; $display("FAIL ignore_lo: got %h expected 0000000c", lo); end
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL ignore_hi: got %h expected 00000000", hi); end
    @(posedge clock); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_no_queue: got %b expected 0", busy); end
  endtask

  task automatic test_mt_writes;
    rs_data = 32'hA5A5A5A5; lo_we = 1'b1;
    @(posedge clock); #1;
    lo_we = 1'b0;
    n_cmp++; if (lo !== 32'hA5A5A5A5) begin n_err++; $display("FAIL mtlo: got %h expected a5a5a5a5", lo); end
    rs_data = 32'h5A5A0001; hi_we = 1'b1;
    @(posedge clock); #1;
    hi_we = 1'b0;
    n_cmp++; if (hi !== 32'h5A5A0001) begin n_err++; $display("FAIL mthi: got %h expected 5a5a0001", hi); end
    n_cmp++; if (lo !== 32'hA5A5A5A5) begin n_err++; $display("FAIL mthi_lo_kept: got %h expected a5a5a5a5", lo); end
    op = MULTU; rs_data = 32'd5; rt_data = 32'd5; start = 1'b1; lo_we = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; lo_we = 1'b0;
    n_cmp++; if (lo !== 32'hA5A5A5A5) begin n_err++; $display("FAIL start_wins: got %h expected a5a5a5a5", lo); end
    for (int i = 0; i < 40 && !done; i++) begin @(posedge clock); #1; end
    n_cmp++; if (lo !== 32'd25) begin n_err++; $display("FAIL start_wins_result: got %0d expected 25", lo); end
  endtask

  task automatic test_reset_abort;
    int lat;
    op = MULT; rs_data = 32'hFFFFFFFB; rt_data = 32'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clock); #1; end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL abort_flags: got %b expected 00", {busy, done}); end
    n_cmp++; if ({hi, lo} !== 64'h0) begin n_err++; $display("FAIL abort_hilo: got %h expected 0", {hi, lo}); end
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    run_op(MULTU, 32'd3, 32'd4, lat);
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL abort_next_latency: got %0d expected 33", lat); end
    n_cmp++; if ({hi, lo} !== 64'd12) begin n_err++; $display("FAIL abort_next: got %h expected 000000000000000c", {hi, lo}); end
  endtask

  task automatic test_back_to_back;
    int lat;
    run_op(DIVU, 32'd100, 32'd7, lat);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_first_done: got %b expected 1", done); end
    run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL b2b_latency: got %0d expected 33", lat); end
    n_cmp++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin n_err++; $display("FAIL b2b_result: got %h expected fffffffe00000001", {hi, lo}); end
  endtask

  initial begin
    test_reset;
    test_multu;
    test_mult;
    test_div;
    test_div_zero;
    test_start_ignored;
    test_mt_writes;
    test_reset_abort;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of run expected completion");
    $fatal(1);
  end
endmodule
